// File: rtl/interrupt_ctrl.sv
// Purpose: 8-line priority interrupt controller with edge capture, mask, global enable and IDLE/PEND/SERVICE handshake.
// Latency: a line rising before edge 1 pends at edge 3; intPending and hvpiAddr are registered and update at edge 4.
// Backpressure: a request stays pending until clrPend acks it; intDisable or enable=0 holds new requests off, with nothing lost.
//
// Ports:
//   clk, resetN                  clock, asynchronous active-low reset
//   intReq[7:0]                  raw device lines (line 0 highest priority)
//   maskIn, MASKld, MASKclr      mask register load / clear (clear wins)
//   INTld, INTclr                global enable set / clear (clear wins)
//   intDisable                   sequencer hold, suppresses new requests
//   clrPend                      acknowledge (honoured only in PEND)
//   intReturn                    end of service (honoured only in SERVICE)
//   intPending, hvpiAddr         registered request and vector address
//   inService, pendingOut        service flag and raw pending register
module interrupt_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] intReq,
    input  logic [7:0] maskIn,
    input  logic       MASKld,
    input  logic       MASKclr,
    input  logic       INTld,
    input  logic       INTclr,
    input  logic       intDisable,
    input  logic       clrPend,
    input  logic       intReturn,
    output logic       intPending,
    output logic [7:0] hvpiAddr,
    output logic       inService,
    output logic [7:0] pendingOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] s1, s2, s3;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       enable;
    logic [2:0] idx_q;

    logic [7:0] rise;
    logic [7:0] cand;
    logic [2:0] idx;
    logic [7:0] clr_vec;

    always_comb begin
        rise = s2 & ~s3;
        cand = pending & mask;
        // Walk from the top down so the lowest set bit is the last one written.
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) idx = 3'(i);
        end
        clr_vec = 8'h00;
        if (state == PEND && clrPend) clr_vec[idx_q] = 1'b1;
    end

    assign pendingOut = pending;

    // Synchroniser, edge capture, mask and enable registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1      <= 8'h00;
            s2      <= 8'h00;
            s3      <= 8'h00;
            pending <= 8'h00;
            mask    <= 8'h00;
            enable  <= 1'b0;
        end else begin
            s1 <= intReq;
            s2 <= s1;
            s3 <= s2;
            // OR-ing rise in after the clear lets a coincident new edge survive the ack.
            pending <= (pending & ~clr_vec) | rise;
            if (MASKclr)     mask <= 8'h00;
            else if (MASKld) mask <= maskIn;
            if (INTclr)      enable <= 1'b0;
            else if (INTld)  enable <= 1'b1;
        end
    end

    // Sequencer handshake FSM; all sequencer-facing outputs are registered here.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            idx_q      <= 3'd0;
            intPending <= 1'b0;
            inService  <= 1'b0;
            hvpiAddr   <= VEC_BASE;
        end else begin
            case (state)
                IDLE: begin
                    if (cand != 8'h00 && enable && !intDisable) begin
                        state      <= PEND;
                        idx_q      <= idx;
                        intPending <= 1'b1;
                        hvpiAddr   <= VEC_BASE + {4'b0000, idx, 1'b0};
                    end
                end
                PEND: begin
                    // The latched vector is held even if a higher-priority line arrives.
                    if (clrPend) begin
                        state      <= SERVICE;
                        intPending <= 1'b0;
                        inService  <= 1'b1;
                        hvpiAddr   <= VEC_BASE;
                    end else if (!enable || intDisable) begin
                        state      <= IDLE;
                        intPending <= 1'b0;
                        hvpiAddr   <= VEC_BASE;
                    end
                end
                SERVICE: begin
                    if (intReturn) begin
                        state     <= IDLE;
                        inService <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    intPending <= 1'b0;
                    inService  <= 1'b0;
                    hvpiAddr   <= VEC_BASE;
                end
            endcase
        end
    end

endmodule
